// File: rtl/lo_phase_sequencer.sv
// lo_phase_sequencer: programmable-rate LO phase counter driving a Gray state bus and a registered one-hot tap select
module lo_phase_sequencer #(
  parameter int N_PHASES = 20,
  parameter int CODE_W = 6,
  parameter int DIV_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [DIV_W-1:0]    div,
  input  logic                dir,
  input  logic                sync,
  output logic [CODE_W-1:0]   phase_idx,
  output logic [CODE_W-1:0]   gray_out,
  output logic [N_PHASES-1:0] phase_oh,
  output logic                wrap
);
  localparam logic [CODE_W-1:0] LAST = CODE_W'(N_PHASES - 1);
  logic [DIV_W-1:0] presc, presc_n, div_q, div_q_n;
  logic [CODE_W-1:0] idx_n;
  logic [N_PHASES-1:0] oh_n;
  logic step, at_end, wrap_n;
  always_comb begin
    step = en & (presc == div_q);
    at_end = dir ? (phase_idx == '0) : (phase_idx == LAST);
    wrap_n = ~sync & step & at_end;
    idx_n = sync ? '0 :
            !step ? phase_idx :
            at_end ? (dir ? LAST : '0) :
            dir ? phase_idx - CODE_W'(1) : phase_idx + CODE_W'(1);
    presc_n = (sync | step) ? '0 : en ? presc + DIV_W'(1) : presc;
    div_q_n = (sync | step) ? div : div_q;
    oh_n = '0;
    // decoded from the next index so the select is a clean register output
    for (int i = 0; i < N_PHASES; i++) oh_n[i] = (idx_n == CODE_W'(i));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
      div_q <= '0;
      phase_idx <= '0;
      gray_out <= '0;
      phase_oh <= N_PHASES'(1);
      wrap <= 1'b0;
    end else begin
      presc <= presc_n;
      div_q <= div_q_n;
      phase_idx <= idx_n;
      gray_out <= idx_n ^ (idx_n >> 1);
      phase_oh <= oh_n;
      wrap <= wrap_n;
    end
  end
endmodule

// File: tb/tb_lo_phase_sequencer.sv
// tb_lo_phase_sequencer: directed vectors with a scoreboard queue checked by a separate monitor
module tb_lo_phase_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0, en = 1'b0, dir = 1'b0, sync = 1'b0;
  logic [7:0] div = '0;
  logic [5:0] phase_idx, gray_out;
  logic [19:0] phase_oh;
  logic wrap;
  logic [3:0] idx16, gray16;
  logic [15:0] oh16;
  logic wrap16;

  typedef struct { int idx; logic w; } exp_t;
  exp_t exp_q[$];
  string nm_q[$];
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  lo_phase_sequencer #(.N_PHASES(20), .CODE_W(6), .DIV_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div(div), .dir(dir), .sync(sync),
    .phase_idx(phase_idx), .gray_out(gray_out), .phase_oh(phase_oh), .wrap(wrap)
  );

  lo_phase_sequencer #(.N_PHASES(16), .CODE_W(4), .DIV_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .div(div), .dir(dir), .sync(sync),
    .phase_idx(idx16), .gray_out(gray16), .phase_oh(oh16), .wrap(wrap16)
  );

  task automatic v(input logic r, input logic e, input logic [7:0] d, input logic dr,
                   input logic s, input int ei, input logic ew, input string nm);
    @(negedge clk);
    rst_n = r; en = e; div = d; dir = dr; sync = s;
    exp_q.push_back('{ei, ew});
    nm_q.push_back(nm);
  endtask

  // scoreboard monitor: one expected entry per clock edge
  initial begin
    exp_t e;
    string nm;
    logic [5:0] eg;
    logic [19:0] eo;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        nm = nm_q.pop_front();
        vectors++;
        eg = 6'(e.idx ^ (e.idx >> 1));
        eo = 20'(1) << e.idx;
        if (phase_idx !== 6'(e.idx) || wrap !== e.w || gray_out !== eg || phase_oh !== eo) begin
          miscompares++;
          $display("FAIL %s: got idx=%0d wrap=%0b gray=%h oh=%h, required idx=%0d wrap=%0b gray=%h oh=%h",
                   nm, phase_idx, wrap, gray_out, phase_oh, e.idx, e.w, eg, eo);
        end
      end
    end
  end

  // invariants on both instances
  initial begin
    logic seen, pv, applied;
    logic [5:0] pidx, pg;
    logic [3:0] pidx16, pg16;
    seen = 1'b0;
    pv = 1'b0;
    pidx = '0; pg = '0; pidx16 = '0; pg16 = '0;
    forever begin
      @(posedge clk);
      #1;
      applied = rst_n & ~sync;
      if (seen) begin
        if (!$onehot(phase_oh) || phase_idx >= 6'd20 || !phase_oh[phase_idx[4:0]]) begin
          miscompares++;
          $display("FAIL inv20_onehot: idx=%0d oh=%h, required single bit at idx < 20", phase_idx, phase_oh);
        end
        if (!$onehot(oh16) || !oh16[idx16]) begin
          miscompares++;
          $display("FAIL inv16_onehot: idx=%0d oh=%h, required single bit at idx", idx16, oh16);
        end
        if (pv && applied && phase_idx != pidx && !wrap && $countones(gray_out ^ pg) != 1) begin
          miscompares++;
          $display("FAIL inv20_gray: %h -> %h, required one-bit change", pg, gray_out);
        end
        if (pv && applied && idx16 != pidx16 && $countones(gray16 ^ pg16) != 1) begin
          miscompares++;
          $display("FAIL inv16_gray: %h -> %h, required one-bit change", pg16, gray16);
        end
      end
      if (!rst_n) seen = 1'b1;
      pv = seen;
      pidx = phase_idx; pg = gray_out; pidx16 = idx16; pg16 = gray16;
    end
  end

  initial begin
    repeat (3) v(0, 0, 0, 0, 0, 0, 0, "reset");
    for (int i = 1; i < 20; i++) v(1, 1, 0, 0, 0, i, 0, "freerun");
    v(1, 1, 0, 0, 0, 0, 1, "wrap_up");
    v(1, 1, 0, 0, 0, 1, 0, "after_wrap");
    repeat (4) v(1, 1, 3, 0, 0, 2, 0, "div3_p2");
    repeat (4) v(1, 1, 3, 0, 0, 3, 0, "div3_p3");
    v(1, 1, 3, 0, 0, 4, 0, "div3_p4");
    repeat (3) v(1, 1, 1, 0, 0, 4, 0, "div_change_p4");
    repeat (2) v(1, 1, 1, 0, 0, 5, 0, "div1_p5");
    repeat (2) v(1, 1, 1, 0, 0, 6, 0, "div1_p6");
    v(1, 1, 1, 0, 0, 7, 0, "div1_p7");
    repeat (5) v(1, 0, 1, 0, 0, 7, 0, "frozen");
    v(1, 1, 1, 0, 0, 7, 0, "presc_up");
    v(1, 0, 0, 0, 1, 0, 0, "sync_no_en");
    v(1, 1, 0, 0, 0, 1, 0, "post_sync_step");
    v(1, 1, 0, 0, 0, 2, 0, "run");
    v(1, 1, 0, 0, 0, 3, 0, "run");
    v(1, 1, 0, 0, 1, 0, 0, "sync_beats_step");
    v(1, 1, 0, 0, 0, 1, 0, "run");
    v(1, 1, 0, 0, 0, 2, 0, "run");
    v(1, 1, 0, 1, 0, 1, 0, "rev");
    v(1, 1, 0, 1, 0, 0, 0, "rev");
    v(1, 1, 0, 1, 0, 19, 1, "wrap_down");
    v(1, 1, 0, 1, 0, 18, 0, "rev");
    v(1, 1, 0, 1, 0, 17, 0, "rev");
    v(1, 1, 0, 0, 0, 18, 0, "fwd_again");
    v(1, 1, 0, 0, 0, 19, 0, "fwd_again");
    v(1, 1, 0, 0, 0, 0, 1, "wrap_up2");
    v(1, 1, 0, 0, 0, 1, 0, "fwd_again");
    for (int i = 2; i < 13; i++) v(1, 1, 0, 0, 0, i, 0, "to13");
    v(1, 1, 5, 0, 0, 13, 0, "to13_div5");
    v(0, 1, 5, 0, 1, 0, 0, "midrun_reset");
    repeat (6) v(1, 1, 5, 0, 0, 1, 0, "restart_p1");
    v(1, 1, 5, 0, 0, 2, 0, "restart_p2");
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
